// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared types and constants for the binary-to-BCD converter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_conv_state_t;

   localparam bcd_digit_t BCD_MAX_DIGIT = 4'h9;
   localparam bcd_digit_t BCD_ERR_DIGIT = 4'hE;

   // Largest value representable in 'digits' decimal digits (10**digits - 1).
   function automatic logic [63:0] bcd_max_value(input int digits);
      logic [63:0] v;
      v = 64'd1;
      for (int i = 0; i < digits; i++) begin
         v = v * 64'd10;
      end
      return v - 64'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dabble_digit.sv
// ============================================================================
// Module  : dabble_digit
// Brief   : Double-dabble digit correction: add 3 when the digit is >= 5.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dabble_digit (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_converter.sv
// ============================================================================
// Module  : bin_to_bcd_converter
// Brief   : Sequential double-dabble binary to packed-BCD converter.
//           BCD_OVERFLOW_SAT_EN: overflow fills with 9s instead of Es.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin_to_bcd_converter
   import bcd_pkg::*;
#(
   parameter int IN_WIDTH = 27,
   parameter int DIGITS   = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [IN_WIDTH-1:0]   bin_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  done_out,
   output logic                  overflow_out
);

   localparam int SW = 4 * DIGITS;
   localparam int CW = $clog2(IN_WIDTH + 1);
   localparam logic [63:0] MAX_VAL = bcd_max_value(DIGITS);
   // When every IN_WIDTH-bit value fits in DIGITS digits, overflow can never occur.
   localparam bit OVF_POSSIBLE = (MAX_VAL < (64'd1 << IN_WIDTH));
   localparam logic [IN_WIDTH-1:0] LIMIT = MAX_VAL[IN_WIDTH-1:0];

`ifdef BCD_OVERFLOW_SAT_EN
   localparam logic [SW-1:0] FILL = {DIGITS{BCD_MAX_DIGIT}};
`else
   localparam logic [SW-1:0] FILL = {DIGITS{BCD_ERR_DIGIT}};
`endif

   bcd_conv_state_t       state_q;
   logic [IN_WIDTH-1:0]   shreg_q, shreg_d;
   logic [SW-1:0]         scratch_q, scratch_d;
   logic [SW-1:0]         corr;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ovf_pend_q;
   logic                  ready_q, done_q, ovf_q;
   logic [SW-1:0]         bcd_q;
   logic                  ovf_now;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      dabble_digit u_dig (
         .digit_i (scratch_q[4*g +: 4]),
         .digit_o (corr[4*g +: 4])
      );
   end

   assign {scratch_d, shreg_d} = {corr, shreg_q} << 1;
   assign cnt_d   = cnt_q - CW'(1);
   assign ovf_now = OVF_POSSIBLE && (bin_in > LIMIT);

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         bcd_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (valid_in && ready_q) begin
                  shreg_q    <= bin_in;
                  scratch_q  <= '0;
                  cnt_q      <= CW'(IN_WIDTH);
                  ovf_pend_q <= ovf_now;
                  ready_q    <= 1'b0;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               shreg_q   <= shreg_d;
               scratch_q <= scratch_d;
               cnt_q     <= cnt_d;
               if (cnt_q == CW'(1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               bcd_q   <= ovf_pend_q ? FILL : scratch_q;
               ovf_q   <= ovf_pend_q;
               done_q  <= 1'b1;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ready_out    = ready_q;
   assign done_out     = done_q;
   assign bcd_out      = bcd_q;
   assign overflow_out = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_converter.sv
// ============================================================================
// Module  : tb_bin_to_bcd_converter
// Brief   : Scoreboard bench for the default and a 4-digit/14-bit converter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_converter;

   localparam int AW = 27;
   localparam int AD = 8;
   localparam int BW = 14;
   localparam int BD = 4;

`ifdef BCD_OVERFLOW_SAT_EN
   localparam logic [3:0] FILL_DIGIT = 4'h9;
`else
   localparam logic [3:0] FILL_DIGIT = 4'hE;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n = 1'b0;
   logic [AW-1:0]   bin_a = '0;
   logic            valid_a = 1'b0;
   logic            ready_a, done_a, ovf_a;
   logic [4*AD-1:0] bcd_a;
   logic [BW-1:0]   bin_b = '0;
   logic            valid_b = 1'b0;
   logic            ready_b, done_b, ovf_b;
   logic [4*BD-1:0] bcd_b;

   bin_to_bcd_converter #(.IN_WIDTH(AW), .DIGITS(AD)) u_dut_a (
      .clk_in       (clk),
      .rst_in       (rst_n),
      .bin_in       (bin_a),
      .valid_in     (valid_a),
      .ready_out    (ready_a),
      .bcd_out      (bcd_a),
      .done_out     (done_a),
      .overflow_out (ovf_a)
   );

   bin_to_bcd_converter #(.IN_WIDTH(BW), .DIGITS(BD)) u_dut_b (
      .clk_in       (clk),
      .rst_in       (rst_n),
      .bin_in       (bin_b),
      .valid_in     (valid_b),
      .ready_out    (ready_b),
      .bcd_out      (bcd_b),
      .done_out     (done_b),
      .overflow_out (ovf_b)
   );

   typedef struct {
      logic [31:0] bcd;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t        q_a[$];
   exp_t        q_b[$];
   exp_t        e_a, e_b;
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [31:0] last_a = '0;
   logic        prev_done_a = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: decimal digits by repeated division, fill pattern when out of range.
   function automatic exp_t model(input longint unsigned v, input int digits);
      exp_t            e;
      longint unsigned lim, t;
      lim = 1;
      for (int i = 0; i < digits; i++) lim = lim * 10;
      e.bcd = '0;
      e.ovf = (v >= lim);
      e.acc = cyc;
      t = v;
      for (int i = 0; i < digits; i++) begin
         if (e.ovf) e.bcd[4*i +: 4] = FILL_DIGIT;
         else       e.bcd[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q_a.delete();
         last_a      = '0;
         prev_done_a = 1'b0;
      end else begin
         if (done_a) begin
            chk("a_done_pulse", 64'(prev_done_a), 64'd0);
            chk("a_queue_nonempty", 64'(q_a.size() != 0), 64'd1);
            if (q_a.size() != 0) begin
               e_a = q_a.pop_front();
               chk("a_bcd", 64'(bcd_a), 64'(e_a.bcd));
               chk("a_ovf", 64'(ovf_a), 64'(e_a.ovf));
               chk("a_latency", 64'(cyc - e_a.acc), 64'(AW + 2));
            end
            last_a = bcd_a;
         end else begin
            chk("a_hold", 64'(bcd_a), 64'(last_a));
            if (q_a.size() != 0) chk("a_ready_busy", 64'(ready_a), 64'd0);
         end
         if (valid_a && ready_a) q_a.push_back(model(64'(bin_a), AD));
         prev_done_a = done_a;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         q_b.delete();
      end else begin
         if (done_b) begin
            chk("b_queue_nonempty", 64'(q_b.size() != 0), 64'd1);
            if (q_b.size() != 0) begin
               e_b = q_b.pop_front();
               chk("b_bcd", 64'(bcd_b), 64'(e_b.bcd));
               chk("b_ovf", 64'(ovf_b), 64'(e_b.ovf));
               chk("b_latency", 64'(cyc - e_b.acc), 64'(BW + 2));
            end
         end
         if (valid_b && ready_b) q_b.push_back(model(64'(bin_b), BD));
      end
   end

   task automatic send_a(input logic [AW-1:0] v);
      int t;
      t = 0;
      @(posedge clk); #2;
      while (!ready_a && t < 100) begin
         @(posedge clk); #2;
         t++;
      end
      chk("a_ready_wait", 64'(ready_a), 64'd1);
      valid_a = 1'b1;
      bin_a   = v;
      @(posedge clk); #2;
      valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [BW-1:0] v);
      int t;
      t = 0;
      @(posedge clk); #2;
      while (!ready_b && t < 100) begin
         @(posedge clk); #2;
         t++;
      end
      chk("b_ready_wait", 64'(ready_b), 64'd1);
      valid_b = 1'b1;
      bin_b   = v;
      @(posedge clk); #2;
      valid_b = 1'b0;
   endtask

   task automatic drain_a();
      int t;
      t = 0;
      while (q_a.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #2;
      chk("a_drain", 64'(q_a.size()), 64'd0);
   endtask

   task automatic drain_b();
      int t;
      t = 0;
      while (q_b.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #2;
      chk("b_drain", 64'(q_b.size()), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("a_rst_ready", 64'(ready_a), 64'd1);
      chk("a_rst_done",  64'(done_a),  64'd0);
      chk("a_rst_bcd",   64'(bcd_a),   64'd0);
      chk("a_rst_ovf",   64'(ovf_a),   64'd0);
      chk("b_rst_ready", 64'(ready_b), 64'd1);
      chk("b_rst_bcd",   64'(bcd_b),   64'd0);

      // Directed values including the decimal range boundaries.
      send_a(AW'(0));           drain_a();
      send_a(AW'(12_345_678));  drain_a();
      send_a(AW'(99_999_999));
      send_a(AW'(100_000_000));
      send_a(AW'(134_217_727));
      send_a(AW'(9));
      drain_a();

      // valid held high while the input changes every cycle.
      @(posedge clk); #2;
      valid_a = 1'b1;
      repeat (120) begin
         bin_a = AW'($urandom_range(134_217_727));
         @(posedge clk); #2;
      end
      valid_a = 1'b0;
      drain_a();

      // Reset in the middle of a conversion aborts it.
      send_a(AW'(77_777_777));
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("a_abort_bcd",   64'(bcd_a),   64'd0);
      chk("a_abort_ready", 64'(ready_a), 64'd1);
      chk("a_abort_done",  64'(done_a),  64'd0);
      repeat (40) @(posedge clk);
      send_a(AW'(42));
      drain_a();
      chk("a_after_abort", 64'(bcd_a), 64'h42);

      // Narrow instance: 4 digits, 14-bit input.
      send_b(BW'(9999));
      send_b(BW'(10000));
      send_b(BW'(16383));
      send_b(BW'(0));
      send_b(BW'(1234));
      drain_b();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
